// File: rtl/cic_pkg.sv
// Shared constants and elaboration-time helpers for the CIC decimation chain
// (integrator/decimator front half and comb back half).
package cic_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 10;
    localparam int R_MIN = 2;
    localparam int R_MAX = 64;

    // Smallest w such that 2**w >= v.
    function automatic int clog2(input int v);
        int w;
        w = 0;
        while ((1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Hogenauer register growth: worst-case bit width through N stages at decimation R.
    function automatic int growth_width(input int in_width, input int n, input int r);
        return in_width + n * clog2(r);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// Single CIC integrator stage: registered modular accumulator, advances only when enabled.
module cic_integrator #(
    parameter int DATA_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [DATA_WIDTH-1:0] dout
);

    // Accumulate din on enabled edges; overflow wraps, which the comb stage relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (en) begin
            dout <= dout + din;
        end
    end

endmodule

// File: rtl/cic_integ_decim.sv
// CIC integrator cascade plus decimate-by-R output register with a one-cycle ND strobe.
module cic_integ_decim
    import cic_pkg::*;
#(
    parameter int N          = 3,
    parameter int R          = 4,
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = growth_width(IN_WIDTH, N, R)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         sync,
    input  logic signed [IN_WIDTH-1:0]   Xin,
    output logic                         ND,
    output logic signed [DATA_WIDTH-1:0] Yout
);

    localparam int            CW       = clog2(R);
    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // stage[0] is the sign-extended input; stage[k] is integrator k output.
    logic signed [DATA_WIDTH-1:0] stage [0:N];
    logic        [CW-1:0]         cnt;
    logic                         emit;

    // Sign-extend the input sample to the internal width.
    always_comb begin
        stage[0] = {{(DATA_WIDTH - IN_WIDTH){Xin[IN_WIDTH-1]}}, Xin};
    end

    // Each stage sums the registered (pre-edge) output of the one before it.
    for (genvar k = 1; k <= N; k++) begin : g_integ
        cic_integrator #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_integ (
            .clk  (clk),
            .rst  (rst),
            .en   (in_valid),
            .din  (stage[k-1]),
            .dout (stage[k])
        );
    end

    // Emit on the last phase of a decimation period unless sync restarts the phase.
    always_comb begin
        emit = in_valid && !sync && (cnt == CNT_LAST);
    end

    // Phase counter: sync takes priority; a synced valid sample is itself phase 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (in_valid) begin
            if (sync) begin
                cnt <= CNT_ONE;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end else if (sync) begin
            cnt <= '0;
        end
    end

    // Output register: capture the last integrator on emission, strobe ND for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Yout <= '0;
            ND   <= 1'b0;
        end else begin
            ND <= emit;
            if (emit) begin
                Yout <= stage[N];
            end
        end
    end

endmodule

// File: tb/tb_cic_integ_decim.sv
// Self-checking bench for cic_integ_decim: closed-form CIC model plus directed scenarios.
module tb_cic_integ_decim;

    localparam int N  = 3;
    localparam int R  = 4;
    localparam int IW = 8;
    localparam int DW = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 sync;
    logic signed [IW-1:0] Xin;
    logic                 ND;
    logic signed [DW-1:0] Yout;

    always #5 clk = ~clk;

    cic_integ_decim #(
        .N          (N),
        .R          (R),
        .IN_WIDTH   (IW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sync     (sync),
        .Xin      (Xin),
        .ND       (ND),
        .Yout     (Yout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: valid samples since reset and the phase of the next valid sample.
    longint               xs[$];
    int                   ph;
    logic                 exp_nd;
    logic signed [DW-1:0] exp_y;
    logic                 nd_n;
    logic signed [DW-1:0] y_n;
    bit                   chk_en = 1'b0;
    logic signed [DW-1:0] got_q[$];

    function automatic longint binom(input int n, input int k);
        longint r;
        if (n < k) return 0;
        r = 1;
        for (int i = 0; i < k; i++) r = r * longint'(n - i) / longint'(i + 1);
        return r;
    endfunction

    // After j valid updates, stage N holds sum_i x[i] * C(j-1-i, N-1) modulo 2**DW.
    function automatic logic signed [DW-1:0] model_out();
        longint acc;
        int     j;
        acc = 0;
        j   = xs.size();
        for (int i = 0; i < j; i++) acc += xs[i] * binom(j - 1 - i, N - 1);
        return DW'(acc);
    endfunction

    task automatic model_edge();
        nd_n = 1'b0;
        if (in_valid) begin
            if (!sync && ph == R - 1) begin
                nd_n = 1'b1;
                y_n  = model_out();
            end
            xs.push_back(longint'(Xin));
            ph = sync ? 1 : (ph + 1) % R;
        end else if (sync) begin
            ph = 0;
        end
    endtask

    // Compare process: registered outputs are checked every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("nd", longint'(ND), longint'(exp_nd));
            chk("yout", longint'(Yout), longint'(exp_y));
            if (ND === 1'b1) got_q.push_back(Yout);
        end
    end

    task automatic tick(input logic v, input logic s, input int x);
        @(negedge clk);
        #1;
        in_valid = v;
        sync     = s;
        Xin      = IW'(x);
        nd_n     = 1'b0;
        if (!rst) model_edge();
        @(posedge clk);
        if (!rst) begin
            exp_nd = nd_n;
            if (nd_n) exp_y = y_n;
        end
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 0);
    endtask

    task automatic rand_tick();
        tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0),
             int'($urandom_range(0, 255)) - 128);
    endtask

    // Assert reset with in_valid high (an emission-bound edge if cnt==R-1), hold, release.
    task automatic do_reset(input int hold);
        @(negedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        sync     = 1'b0;
        Xin      = '0;
        xs.delete();
        got_q.delete();
        ph     = 0;
        exp_nd = 1'b0;
        exp_y  = '0;
        chk_en = 1'b1;
        #1;
        chk("rst_nd_now", longint'(ND), 0);
        chk("rst_y_now", longint'(Yout), 0);
        repeat (hold) rand_tick();
        @(negedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        sync     = 1'b0;
        Xin      = '0;
    endtask

    task automatic impulse_run(input string tag);
        int ref_y[4];
        ref_y = '{1, 15, 45, 91};
        got_q.delete();
        tick(1'b1, 1'b0, 1);
        repeat (15) tick(1'b1, 1'b0, 0);
        idle();
        chk({tag, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) chk($sformatf("%s_y%0d", tag, i), longint'(got_q[i]), ref_y[i]);
        end
    endtask

    int                   samp[40];
    logic signed [DW-1:0] ref_q[$];
    logic signed [DW-1:0] cs[3];
    logic signed [DW-1:0] v, t;
    int                   bad;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sync     = 1'b0;
        Xin      = '0;
        exp_nd   = 1'b0;
        exp_y    = '0;
        ph       = 0;

        // 1: reset held with random traffic, then first emission on the 4th valid sample
        do_reset(6);
        repeat (3) tick(1'b1, 1'b0, int'($urandom_range(0, 255)) - 128);
        idle();
        chk("s1_no_nd_3", got_q.size(), 0);
        tick(1'b1, 1'b0, int'($urandom_range(0, 255)) - 128);
        idle();
        chk("s1_nd_4th", got_q.size(), 1);

        // 2: impulse response
        do_reset(2);
        impulse_run("s2");

        // 6: reset on an emission-bound cycle, then a fresh impulse
        do_reset(2);
        tick(1'b1, 1'b0, 1);
        repeat (6) tick(1'b1, 1'b0, 0);
        idle();
        chk("s6_y_before", longint'(Yout), 1);
        do_reset(2);
        impulse_run("s6");

        // 3: full-scale negative DC through a downstream order-3 comb
        do_reset(2);
        repeat (200) tick(1'b1, 1'b0, -128);
        idle();
        chk("s3_count", got_q.size(), 50);
        cs  = '{default: '0};
        bad = 0;
        for (int k = 0; k < got_q.size(); k++) begin
            v = got_q[k];
            for (int s = 0; s < 3; s++) begin
                t     = v - cs[s];
                cs[s] = v;
                v     = t;
            end
            if (k >= 3 && v != -14'sd8192) bad++;
            if (k == 49) chk("s3_comb_last", longint'(v), -8192);
        end
        chk("s3_comb_bad", bad, 0);

        // 4: gapped valid must match the gapless run of the same samples
        for (int i = 0; i < 40; i++) samp[i] = int'($urandom_range(0, 255)) - 128;
        do_reset(2);
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, samp[i]);
        idle();
        ref_q = got_q;
        chk("s4_ref_count", ref_q.size(), 10);
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 5)) idle();
            tick(1'b1, 1'b0, samp[i]);
        end
        idle();
        chk("s4_gap_count", got_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size() && i < ref_q.size())
                chk($sformatf("s4_y%0d", i), longint'(got_q[i]), longint'(ref_q[i]));
        end

        // 5: sync on the cnt==2 sample restarts the phase
        do_reset(2);
        tick(1'b1, 1'b0, 5);
        tick(1'b1, 1'b0, -3);
        tick(1'b1, 1'b1, 7);
        idle();
        chk("s5_no_nd_sync", got_q.size(), 0);
        tick(1'b1, 1'b0, 2);
        tick(1'b1, 1'b0, 1);
        idle();
        chk("s5_no_nd_early", got_q.size(), 0);
        tick(1'b1, 1'b0, 4);
        idle();
        chk("s5_nd_after", got_q.size(), 1);

        // 7: random valid/sync traffic against the model
        do_reset(2);
        repeat (400) rand_tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
